// File: rtl/bcrypt_core_rx_pkg.sv
// Shared bus definitions for the arbiter-to-core batch link: ctrl codes,
// receiver states and transfer word counts used by both ends of the link.
package bcrypt_core_rx_pkg;

    typedef enum logic [1:0] {
        CTRL_NONE       = 2'd0,
        CTRL_INIT_START = 2'd1,
        CTRL_DATA_START = 2'd2,
        CTRL_END        = 2'd3
    } ctrl_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RX_P      = 3'd1,
        ST_RX_S      = 3'd2,
        ST_RX_DATA   = 3'd3,
        ST_DONE_INIT = 3'd4,
        ST_DONE_DATA = 3'd5
    } state_e;

    localparam int INIT_P_WORDS_DEF = 30;
    localparam int S_WORDS_DEF      = 1024;
    localparam int DATA_WORDS_DEF   = 31;
    localparam int DATA_P_BASE_DEF  = 32;

    localparam int WORD_CNT_W = 11;
    localparam int ADDR_W     = 10;
    localparam int BYTE_CNT_W = 2;

    function automatic logic is_start(input logic [1:0] code);
        return (code == CTRL_INIT_START) || (code == CTRL_DATA_START);
    endfunction

endpackage

// File: rtl/bcrypt_core_rx_byte_deser.sv
// Four-byte little-endian deserializer: byte k of a word lands in bits
// [8k+7:8k]; o_word_done flags the cycle carrying the fourth byte.
module bcrypt_core_rx_byte_deser
    import bcrypt_core_rx_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_done
);

    logic [23:0]           r_shift;
    logic [BYTE_CNT_W-1:0] r_byte_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (i_clr) begin
            r_byte_cnt <= '0;
        end else if (i_valid) begin
            r_shift    <= {i_byte, r_shift[23:8]};
            r_byte_cnt <= r_byte_cnt + 1'b1;
        end
    end

    // The fourth byte is taken straight from the bus so the word is whole in its own cycle
    assign o_word      = {i_byte, r_shift};
    assign o_word_done = i_valid && (r_byte_cnt == '1);

endmodule

// File: rtl/bcrypt_core_rx.sv
// Core-side batch bus receiver: assembles words, routes them to the P-region or
// S-box write port and reports init/data completion and protocol errors.
module bcrypt_core_rx
    import bcrypt_core_rx_pkg::*;
#(
    parameter int INIT_P_WORDS = INIT_P_WORDS_DEF,
    parameter int S_WORDS      = S_WORDS_DEF,
    parameter int DATA_WORDS   = DATA_WORDS_DEF,
    parameter int DATA_P_BASE  = DATA_P_BASE_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [7:0]        i_din,
    input  logic [1:0]        i_ctrl,
    input  logic              i_data_ack,
    output logic              o_wr_en,
    output logic              o_wr_sel,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [31:0]       o_wr_data,
    output logic              o_init_loaded,
    output logic              o_data_ready,
    output logic              o_busy,
    output logic [2:0]        o_error
);

    state_e                r_state;
    logic [WORD_CNT_W-1:0] r_word_cnt;
    logic                  r_wr_en;
    logic                  r_wr_sel;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic [31:0]           r_wr_data;
    logic                  r_init_loaded;
    logic                  r_data_ready;
    logic                  r_busy;
    logic [2:0]            r_error;

    ctrl_e                 w_ctrl;
    logic                  w_in_rx;
    logic                  w_start;
    logic                  w_end;
    logic                  w_word_done;
    logic                  w_at_last;
    logic [31:0]           w_word;
    logic [WORD_CNT_W-1:0] w_last_idx;
    logic                  w_wr_sel;
    logic [ADDR_W-1:0]     w_wr_addr;

    assign w_ctrl  = ctrl_e'(i_ctrl);
    assign w_start = is_start(i_ctrl);
    assign w_end   = (w_ctrl == CTRL_END);
    assign w_in_rx = r_state inside {ST_RX_P, ST_RX_S, ST_RX_DATA};

    bcrypt_core_rx_byte_deser u_deser (
        .i_clk       (i_clk),
        .i_rst       (i_reset),
        .i_clr       (!w_in_rx || w_start),
        .i_valid     (w_in_rx && !w_start),
        .i_byte      (i_din),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    always_comb begin
        w_last_idx = WORD_CNT_W'(INIT_P_WORDS - 1);
        w_wr_sel   = 1'b0;
        w_wr_addr  = r_word_cnt[ADDR_W-1:0];
        if (r_state == ST_RX_S) begin
            w_last_idx = WORD_CNT_W'(S_WORDS - 1);
            w_wr_sel   = 1'b1;
        end else if (r_state == ST_RX_DATA) begin
            w_last_idx = WORD_CNT_W'(DATA_WORDS - 1);
            w_wr_addr  = ADDR_W'(DATA_P_BASE) + r_word_cnt[ADDR_W-1:0];
        end
    end

    assign w_at_last = (r_word_cnt == w_last_idx);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_word_cnt    <= '0;
            r_wr_en       <= 1'b0;
            r_wr_sel      <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_init_loaded <= 1'b0;
            r_data_ready  <= 1'b0;
            r_busy        <= 1'b0;
            r_error       <= '0;
        end else begin
            r_wr_en <= 1'b0;
            // A completion landing in the same cycle as an ack keeps data_ready set
            if (i_data_ack && r_state != ST_DONE_DATA) begin
                r_data_ready <= 1'b0;
            end

            if (w_start) begin
                if (w_in_rx) begin
                    r_error[0] <= 1'b1;
                end
                r_word_cnt <= '0;
                if (w_ctrl == CTRL_INIT_START) begin
                    r_state       <= ST_RX_P;
                    r_init_loaded <= 1'b0;
                    r_busy        <= 1'b1;
                end else if (r_init_loaded && !r_data_ready) begin
                    r_state <= ST_RX_DATA;
                    r_busy  <= 1'b1;
                end else begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_error[2] <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE_INIT, ST_DONE_DATA: begin
                        if (w_end) begin
                            r_error[1] <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                    ST_RX_P: begin
                        if (w_end) begin
                            r_state    <= ST_IDLE;
                            r_busy     <= 1'b0;
                            r_word_cnt <= '0;
                            r_error[1] <= 1'b1;
                        end else if (w_word_done) begin
                            r_wr_en    <= 1'b1;
                            r_wr_sel   <= w_wr_sel;
                            r_wr_addr  <= w_wr_addr;
                            r_wr_data  <= w_word;
                            r_word_cnt <= w_at_last ? '0 : r_word_cnt + 1'b1;
                            if (w_at_last) begin
                                r_state <= ST_RX_S;
                            end
                        end
                    end
                    ST_RX_S, ST_RX_DATA: begin
                        if (w_end && w_word_done && w_at_last) begin
                            r_wr_en    <= 1'b1;
                            r_wr_sel   <= w_wr_sel;
                            r_wr_addr  <= w_wr_addr;
                            r_wr_data  <= w_word;
                            r_word_cnt <= '0;
                            r_busy     <= 1'b0;
                            if (r_state == ST_RX_S) begin
                                r_state       <= ST_DONE_INIT;
                                r_init_loaded <= 1'b1;
                            end else begin
                                r_state      <= ST_DONE_DATA;
                                r_data_ready <= 1'b1;
                            end
                        end else if (w_end || (w_word_done && w_at_last)) begin
                            // Short transfer, or the last word arrived without END: drop it
                            r_state    <= ST_IDLE;
                            r_busy     <= 1'b0;
                            r_word_cnt <= '0;
                            r_error[1] <= 1'b1;
                        end else if (w_word_done) begin
                            r_wr_en    <= 1'b1;
                            r_wr_sel   <= w_wr_sel;
                            r_wr_addr  <= w_wr_addr;
                            r_wr_data  <= w_word;
                            r_word_cnt <= r_word_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_wr_en       = r_wr_en;
    assign o_wr_sel      = r_wr_sel;
    assign o_wr_addr     = r_wr_addr;
    assign o_wr_data     = r_wr_data;
    assign o_init_loaded = r_init_loaded;
    assign o_data_ready  = r_data_ready;
    assign o_busy        = r_busy;
    assign o_error       = r_error;

endmodule

// File: tb/tb_bcrypt_core_rx.sv
// Self-checking bench for bcrypt_core_rx: transfer-level reference model predicts
// the write stream, completion flags and sticky error bits for each transfer.
module tb_bcrypt_core_rx;
    import bcrypt_core_rx_pkg::*;

    localparam int P_WORDS = INIT_P_WORDS_DEF;
    localparam int W_INIT  = INIT_P_WORDS_DEF + S_WORDS_DEF;
    localparam int W_DATA  = DATA_WORDS_DEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic [1:0]  ctrl;
    logic        data_ack;
    logic        wr_en;
    logic        wr_sel;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        init_loaded;
    logic        data_ready;
    logic        busy;
    logic [2:0]  error;

    always #5 clk = ~clk;

    bcrypt_core_rx dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_din         (din),
        .i_ctrl        (ctrl),
        .i_data_ack    (data_ack),
        .o_wr_en       (wr_en),
        .o_wr_sel      (wr_sel),
        .o_wr_addr     (wr_addr),
        .o_wr_data     (wr_data),
        .o_init_loaded (init_loaded),
        .o_data_ready  (data_ready),
        .o_busy        (busy),
        .o_error       (error)
    );

    int checks = 0;
    int errors = 0;

    logic [42:0] wr_q[$];
    logic [42:0] exp_q[$];
    logic [31:0] words[W_INIT];

    bit       m_init;
    bit       m_ready;
    bit       m_busy;
    logic [2:0] m_err;

    always @(posedge clk) begin
        #1;
        if (wr_en === 1'b1) wr_q.push_back({wr_sel, wr_addr, wr_data});
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] c, input logic [7:0] b);
        ctrl = c;
        din  = b;
        @(negedge clk);
    endtask

    task automatic check_flags(input string tag);
        check({tag, ".init_loaded"}, init_loaded, m_init);
        check({tag, ".data_ready"}, data_ready, m_ready);
        check({tag, ".busy"}, busy, m_busy);
        check({tag, ".error"}, error, m_err);
    endtask

    task automatic check_writes(input string tag);
        check({tag, ".nwr"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            check({tag, ".wr"}, wr_q[i], exp_q[i]);
        wr_q.delete();
        exp_q.delete();
    endtask

    // term: 0 = END on the last byte, 1 = no END at all, 2 = next START follows directly
    task automatic run_xfer(input string tag, input bit is_init, input int nbytes,
                            input int term, input int pattern);
        int w_total;
        int nw_none;
        int nwr;
        int addr;
        bit accept;
        bit legal;
        logic [1:0] c;
        w_total = is_init ? W_INIT : W_DATA;
        accept  = is_init || (m_init && !m_ready);
        if (m_busy) m_err[0] = 1'b1;
        wr_q.delete();
        drive(is_init ? CTRL_INIT_START : CTRL_DATA_START, 8'h00);
        if (!accept) begin
            m_err[2] = 1'b1;
            m_busy   = 1'b0;
            ctrl = CTRL_NONE;
            repeat (3) @(negedge clk);
            check_writes(tag);
            check_flags(tag);
            $display("xfer %s: init=%0d rejected err=%b", tag, is_init, error);
            return;
        end
        if (is_init) m_init = 1'b0;
        m_busy = 1'b1;
        check({tag, ".start_busy"}, busy, 1'b1);
        for (int i = 0; i < w_total; i++) begin
            if (pattern == 1)
                words[i] = is_init ? ((i >= P_WORDS) ? 32'(i - P_WORDS) : 32'(i))
                                   : 32'hA000_0000 + 32'(i);
            else
                words[i] = $urandom;
        end
        for (int b = 0; b < nbytes; b++) begin
            c = (term == 0 && b == nbytes - 1) ? CTRL_END : CTRL_NONE;
            drive(c, 8'(words[b / 4] >> (8 * (b % 4))));
        end
        legal   = (term == 0) && (nbytes == 4 * w_total);
        nw_none = (term == 0 && nbytes % 4 == 0) ? nbytes / 4 - 1 : nbytes / 4;
        nwr     = legal ? w_total : ((nw_none < w_total) ? nw_none : w_total - 1);
        for (int i = 0; i < nwr; i++) begin
            addr = is_init ? ((i >= P_WORDS) ? i - P_WORDS : i) : DATA_P_BASE_DEF + i;
            exp_q.push_back({(is_init && i >= P_WORDS), 10'(addr), words[i]});
        end
        if (legal) begin
            if (is_init) m_init = 1'b1;
            else         m_ready = 1'b1;
            m_busy = 1'b0;
            check({tag, ".last_wr_en"}, wr_en, 1'b1);
            check({tag, ".flag_at_done"}, is_init ? init_loaded : data_ready, 1'b1);
            check({tag, ".busy_at_done"}, busy, 1'b0);
        end else if (term != 2) begin
            m_err[1] = 1'b1;
            m_busy   = 1'b0;
        end
        if (term != 2) begin
            ctrl = CTRL_NONE;
            din  = 8'h00;
            repeat (3) @(negedge clk);
        end
        check_writes(tag);
        check_flags(tag);
        $display("xfer %s: init=%0d bytes=%0d term=%0d writes=%0d err=%b",
                 tag, is_init, nbytes, term, nwr, error);
    endtask

    task automatic pulse_ack(input string tag);
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        m_ready  = 1'b0;
        check({tag, ".data_ready"}, data_ready, 1'b0);
        $display("ack %s: data_ready=%0d", tag, data_ready);
    endtask

    task automatic hard_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, ".outs"}, {wr_en, wr_sel, wr_addr, wr_data, init_loaded, data_ready, busy, error}, '0);
        @(negedge clk);
        ctrl = CTRL_NONE;
        din  = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        m_init = 1'b0; m_ready = 1'b0; m_busy = 1'b0; m_err = '0;
        wr_q.delete();
        exp_q.delete();
        repeat (3) @(negedge clk);
        check({tag, ".nwr"}, wr_q.size(), 0);
        check_flags(tag);
        $display("reset %s: busy=%0d err=%b", tag, busy, error);
    endtask

    initial begin
        int t;
        rst = 1'b1; ctrl = CTRL_NONE; din = 8'h00; data_ack = 1'b0;
        m_init = 1'b0; m_ready = 1'b0; m_busy = 1'b0; m_err = '0;
        repeat (2) @(negedge clk);
        check("por.outs", {wr_en, wr_sel, wr_addr, wr_data, init_loaded, data_ready, busy, error}, '0);
        rst = 1'b0;
        @(negedge clk);

        run_xfer("data_no_init", 1'b0, 0, 0, 0);
        hard_reset("rst0");
        run_xfer("init_ramp", 1'b1, 4 * W_INIT, 0, 1);
        run_xfer("data_ramp", 1'b0, 4 * W_DATA, 0, 1);
        run_xfer("data_while_ready", 1'b0, 0, 0, 0);
        pulse_ack("ack0");
        run_xfer("data_short20", 1'b0, 4 * 20, 0, 0);
        run_xfer("data_short_b1", 1'b0, 4 * $urandom_range(0, 29) + 2, 0, 0);
        run_xfer("data_ok1", 1'b0, 4 * W_DATA, 0, 0);
        pulse_ack("ack1");
        run_xfer("data_overrun", 1'b0, 4 * W_DATA, 1, 0);
        run_xfer("data_cut", 1'b0, $urandom_range(1, 4 * W_DATA - 1), 2, 0);
        run_xfer("data_restart", 1'b0, 4 * W_DATA, 0, 0);
        pulse_ack("ack2");
        run_xfer("init_cut_s500", 1'b1, 4 * (P_WORDS + 500) + $urandom_range(0, 3), 2, 0);
        run_xfer("init_full", 1'b1, 4 * W_INIT, 0, 0);

        for (int i = 0; i < 6; i++) begin
            t = $urandom_range(0, 3);
            case (t)
                0: run_xfer("rnd_ok", 1'b0, 4 * W_DATA, 0, 0);
                1: run_xfer("rnd_short", 1'b0, $urandom_range(4, 4 * W_DATA - 1), 0, 0);
                2: begin
                    run_xfer("rnd_cut", 1'b0, $urandom_range(1, 4 * W_DATA - 1), 2, 0);
                    run_xfer("rnd_after_cut", 1'b0, 4 * W_DATA, 0, 0);
                end
                default: pulse_ack("rnd_ack");
            endcase
        end

        run_xfer("init_cut_p", 1'b1, 4 * 12 + 2, 2, 0);
        hard_reset("rst_mid_p");
        run_xfer("init_after_rst", 1'b1, 4 * W_INIT, 0, 0);
        run_xfer("data_after_rst", 1'b0, 4 * W_DATA, 0, 0);
        pulse_ack("ack_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcrypt_core_rx.md
Name: bcrypt_core_rx

Overview:
- Core-side receiver for the 10-bit arbiter-to-core batch bus: 8-bit data plus 2-bit ctrl.
- Deserializes bytes, least-significant byte first, into 32-bit words.
- Routes each word to the core's P-region or S-box write port.
- Tracks init (P + S) and data (P-region) transfers, raises completion flags towards the core's compute FSM, and flags protocol violations.

Parameters:
- INIT_P_WORDS, 30, words in the P-region part of an init transfer (addr 0..29).
- S_WORDS, 1024, S-box words following the P part of an init transfer.
- DATA_WORDS, 31, words in a data transfer.
- DATA_P_BASE, 32, P-region address of the first data word.

Ports:
- CLK  in  1  clock
- reset  in  1  asynchronous, active-high
- din  in  8  bus data byte
- ctrl  in  2  bus control code
- wr_en  out  1  one-cycle word write strobe
- wr_sel  out  1  0 = P-region, 1 = S-box
- wr_addr  out  10  word address (P: 0..63, S: 0..1023)
- wr_data  out  32  assembled word
- init_loaded  out  1  level: a complete init transfer has been received
- data_ready  out  1  level: a complete data batch is loaded
- data_ack  in  1  core consumed the batch; clears data_ready
- busy  out  1  receiver is inside a transfer
- error  out  3  sticky error bits

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; byte and word counters 0.
- Ctrl codes: NONE=0, INIT_START=1, DATA_START=2, END=3.
- A START cycle carries no data byte.
- Every following NONE cycle carries one byte.
- The END cycle carries the final byte, i.e. byte 3 of the last word.
- Byte assembly: shift register; byte k goes to bits [8k+7:8k].
- A word completes when byte_cnt==3. On the next cycle: wr_en=1 with wr_data/wr_sel/wr_addr valid. Latency is 1 cycle after the 4th byte.
- FSM states:
  - IDLE:
    - INIT_START -> RX_P: word_cnt=0, init_loaded<=0, busy<=1.
    - DATA_START -> RX_DATA, if init_loaded==1 and data_ready==0. Otherwise set error[2] and stay IDLE; no writes.
    - END in IDLE -> error[1]. NONE is ignored.
  - RX_P:
    - Words go to wr_sel=0, wr_addr=word_cnt.
    - After word INIT_P_WORDS-1 -> RX_S with word_cnt=0.
  - RX_S:
    - Words go to wr_sel=1, wr_addr=word_cnt[9:0].
    - END together with the last byte of word S_WORDS-1 -> DONE_INIT.
  - RX_DATA:
    - Words go to wr_sel=0, wr_addr=DATA_P_BASE+word_cnt.
    - END together with the last byte of word DATA_WORDS-1 -> DONE_DATA.
  - DONE_INIT: init_loaded<=1, busy<=0 -> IDLE.
  - DONE_DATA: data_ready<=1, busy<=0 -> IDLE.
  - Both DONE states are entered the cycle after END. The last word's wr_en coincides with the DONE state.
- Count check:
  - END arriving with byte_cnt!=3, or with the wrong word count, sets error[1].
  - Any partial word is discarded; the FSM returns to IDLE with no completion flag.
  - A further NONE byte in RX_S/RX_DATA after the last word was expected also sets error[1] and returns to IDLE.
- START while busy: sets error[0], abandons the current transfer, and restarts per the new START code (same rules as IDLE). A partially received init leaves init_loaded=0.
- data_ack clears data_ready the next cycle. If data_ack coincides with DONE_DATA, the set wins.
- Errors are sticky until reset.
- Reset mid-transfer: everything returns immediately to reset values and no further wr_en is issued.
- Word counter is 11 bits wide and never wraps within a legal transfer.

Decomposition:
- Shared package/header (bcrypt.vh): the ctrl code constants (CTRL_NONE, CTRL_INIT_START, CTRL_DATA_START, CTRL_END) and the word-count constants. The transmitter uses the same definitions.
- Natural sub-module: bcrypt_byte_deser, a 4-byte little-endian shift register with a word-complete strobe and a clear input.

Test Plan:
- Init: INIT_START, then 30 P words, then 1024 S words with S[i]=i; END on the last byte.
  - 30 writes sel=0, addr 0..29, then 1024 writes sel=1 with data==addr.
  - init_loaded=1 one cycle after END; busy=0; error=0.
- Data after init: DATA_START, then 31 words 0xA0000000+n; END on the last byte.
  - Writes at P addr 32..62.
  - data_ready=1.
  - data_ack pulse clears it next cycle.
- DATA_START before any init: error=3'b100, no wr_en, FSM stays IDLE.
- Second DATA_START while data_ready=1: error[2] set, no writes, data_ready remains 1.
- Short data (END after 20 words, or with byte_cnt=1): error[1] set; data_ready stays 0; next legal data transfer succeeds.
- INIT_START during RX_S at word 500: error[0] set; new init restarts at P addr 0; init_loaded=1 only after the new full init.
- Reset asserted mid-RX_P: all outputs 0 asynchronously; a subsequent full init completes cleanly.
